// File: rtl/dsp_pkg.sv
// Shared definitions for the fetch unit and the control LUT: NOP encoding,
// PC-select codes, default widths, opcode field positions and FSM states.
package dsp_pkg;

    localparam int DEF_PC_W    = 12;
    localparam int DEF_INSTR_W = 16;

    localparam logic [15:0] NOP_INSTR = 16'h7F80;

    localparam logic [1:0] PC_SEL_BRANCH = 2'b00;
    localparam logic [1:0] PC_SEL_ACC    = 2'b01;
    localparam logic [1:0] PC_SEL_HALT   = 2'b10;
    localparam logic [1:0] PC_SEL_SEQ    = 2'b11;

    localparam int OP_DK_MSB = 15;
    localparam int OP_DK_LSB = 8;
    localparam int OP_S_MSB  = 15;
    localparam int OP_S_LSB  = 12;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Issue-side handshake between the fetch unit (master) and the decoder (slave).
interface instr_fetch_if
    import dsp_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
);

    logic [INSTR_W-1:0] instr_out;
    logic [7:0]         OP_dk;
    logic [3:0]         OP_s;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;

    modport master (
        output instr_out, OP_dk, OP_s, instr_pc, instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr_out, OP_dk, OP_s, instr_pc, instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instruction, pc}; slot 0 is always the head.
module fetch_queue
    import dsp_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [INSTR_W-1:0] push_instr,
    input  logic [PC_W-1:0]    push_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [PC_W-1:0]    head_pc,
    output logic [1:0]         count
);

    logic [INSTR_W-1:0] instr_mem [2];
    logic [PC_W-1:0]    pc_mem    [2];
    logic               do_push;
    logic               do_pop;
    logic               write_head;

    assign do_pop     = pop && (count != 2'd0);
    assign do_push    = push && ((count != 2'd2) || do_pop);
    // A pushed word goes to the head slot when nothing else remains after this edge's pop.
    assign write_head = (count == 2'd0) || ((count == 2'd1) && do_pop);

    assign head_instr = instr_mem[0];
    assign head_pc    = pc_mem[0];

    // Storage and occupancy; a flush overrides any push or pop on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= 2'd0;
            instr_mem[0] <= INSTR_W'(NOP_INSTR);
            instr_mem[1] <= INSTR_W'(NOP_INSTR);
            pc_mem[0]    <= '0;
            pc_mem[1]    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            if (do_pop) begin
                instr_mem[0] <= instr_mem[1];
                pc_mem[0]    <= pc_mem[1];
            end
            if (do_push) begin
                if (write_head) begin
                    instr_mem[0] <= push_instr;
                    pc_mem[0]    <= push_pc;
                end else begin
                    instr_mem[1] <= push_instr;
                    pc_mem[1]    <= push_pc;
                end
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: drives the synchronous program ROM, buffers
// returned words in a 2-entry queue and presents the head to the decoder.
module instr_fetch
    import dsp_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INSTR_W  = DEF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    prog_addr,
    output logic               prog_en,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               redirect_valid,
    input  logic [1:0]         pc_sel,
    input  logic [PC_W-1:0]    branch_addr,
    input  logic [PC_W-1:0]    acc_lo,
    input  logic               resume,
    output logic               halted,
    instr_fetch_if.master      issue
);

    fetch_state_t       state;
    fetch_state_t       next_state;
    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    inflight_pc;
    logic [PC_W-1:0]    target;
    logic               inflight;
    logic               jump_req;
    logic               halt_req;
    logic               flush;
    logic               pop;
    logic               push;
    logic [1:0]         q_count;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_pc;

    assign jump_req = redirect_valid && ((pc_sel == PC_SEL_BRANCH) || (pc_sel == PC_SEL_ACC));
    assign halt_req = redirect_valid && (pc_sel == PC_SEL_HALT);
    assign flush    = jump_req || halt_req;
    // Halt also parks its resume address in fetch_pc, so it shares the branch_addr path.
    assign target   = (pc_sel == PC_SEL_ACC) ? acc_lo : branch_addr;
    assign pop      = issue.instr_valid && issue.instr_ready && !flush;
    assign push     = inflight && !flush;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Next state and ROM read enable.
    always_comb begin
        next_state = state;
        prog_en    = 1'b0;
        case (state)
            ST_BOOT: begin
                next_state = halt_req ? ST_HALT : ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) begin
                    next_state = ST_HALT;
                end
                // The head leaving on this edge frees its slot, which sustains one fetch per cycle.
                prog_en = ({1'b0, q_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
            end
            ST_HALT: begin
                if (resume && !halt_req) begin
                    next_state = ST_RUN;
                end
            end
            default: begin
                next_state = ST_BOOT;
            end
        endcase
    end

    // PC sequencing and tracking of the single read the ROM may have in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (flush) begin
                fetch_pc <= target;
            end else if (prog_en) begin
                fetch_pc <= fetch_pc + PC_W'(1);
            end
            inflight <= prog_en && !flush;
            if (prog_en) begin
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_queue #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_instr (prog_data),
        .push_pc    (inflight_pc),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (q_count)
    );

    assign prog_addr = fetch_pc;
    assign halted    = (state == ST_HALT);

    assign issue.instr_valid = (q_count != 2'd0);
    assign issue.instr_out   = issue.instr_valid ? head_instr : INSTR_W'(NOP_INSTR);
    assign issue.instr_pc    = issue.instr_valid ? head_pc : '0;
    assign issue.OP_dk       = issue.instr_out[OP_DK_MSB:OP_DK_LSB];
    assign issue.OP_s        = issue.instr_out[OP_S_MSB:OP_S_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed start-up/stall/reset sequences, a table of
// redirect cases, and a randomized phase checked against a stream-level model.
module tb_instr_fetch;
    import dsp_pkg::*;

    localparam int PC_W    = 12;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [PC_W-1:0]    prog_addr;
    logic               prog_en;
    logic [INSTR_W-1:0] prog_data = '0;
    logic               redirect_valid;
    logic [1:0]         pc_sel;
    logic [PC_W-1:0]    branch_addr;
    logic [PC_W-1:0]    acc_lo;
    logic               resume;
    logic               halted;
    logic [PC_W-1:0]    last_read = '0;

    int tests = 0;
    int fails = 0;

    instr_fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(12'h000)) dut (
        .clk            (clk),
        .reset          (reset),
        .prog_addr      (prog_addr),
        .prog_en        (prog_en),
        .prog_data      (prog_data),
        .redirect_valid (redirect_valid),
        .pc_sel         (pc_sel),
        .branch_addr    (branch_addr),
        .acc_lo         (acc_lo),
        .resume         (resume),
        .halted         (halted),
        .issue          (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [11:0] a);
        return 16'h1000 + {4'h0, a};
    endfunction

    // Synchronous ROM with one cycle of read latency.
    always @(posedge clk) begin
        if (prog_en) begin
            prog_data <= rom_word(prog_addr);
            last_read <= prog_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_head(input string name, input logic [11:0] pc);
        logic [15:0] w;
        w = rom_word(pc);
        chk({name, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({name, "_pc"}, 32'(bus.instr_pc), 32'(pc));
        chk({name, "_instr"}, 32'(bus.instr_out), 32'(w));
        chk({name, "_opdk"}, 32'(bus.OP_dk), 32'(w[15:8]));
        chk({name, "_ops"}, 32'(bus.OP_s), 32'(w[15:12]));
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, "_addr"}, 32'(prog_addr), 32'h000);
        chk({name, "_en"}, 32'(prog_en), 32'd0);
        chk({name, "_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({name, "_instr"}, 32'(bus.instr_out), 32'h7F80);
        chk({name, "_pc"}, 32'(bus.instr_pc), 32'h000);
        chk({name, "_halted"}, 32'(halted), 32'd0);
    endtask

    // Called right after reset is released on a negedge with instr_ready=1.
    task automatic startup_check(input string name);
        @(negedge clk);
        chk({name, "_boot_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({name, "_first_en"}, 32'(prog_en), 32'd1);
        chk({name, "_first_addr"}, 32'(prog_addr), 32'h000);
        @(negedge clk);
        chk({name, "_lat_valid"}, 32'(bus.instr_valid), 32'd0);
        @(negedge clk);
        chk_head({name, "_first"}, 12'h000);
    endtask

    typedef struct packed {
        logic [1:0]  sel;
        logic [11:0] branch;
        logic [11:0] acc;
        logic        seq;
        logic        halt;
        logic [11:0] target;
    } redir_vec_t;

    redir_vec_t vecs [6];

    logic [11:0] cur;
    logic [11:0] p;
    logic [11:0] ahead;

    // Randomized-phase model state: the pc the next valid head must carry.
    logic [11:0] m_exp;
    bit          m_halted;
    bit          was_halted;
    int          idle;
    bit          prev_redir;
    logic [1:0]  prev_sel;
    logic [11:0] prev_branch;
    logic [11:0] prev_acc;
    bit          prev_resume;
    bit          prev_valid;
    bit          prev_ready;
    bit          jmp;
    bit          hlt;

    initial begin
        vecs[0] = '{sel: PC_SEL_BRANCH, branch: 12'h123, acc: 12'h555, seq: 1'b0, halt: 1'b0, target: 12'h123};
        vecs[1] = '{sel: PC_SEL_ACC,    branch: 12'h777, acc: 12'hFFE, seq: 1'b0, halt: 1'b0, target: 12'hFFE};
        vecs[2] = '{sel: PC_SEL_SEQ,    branch: 12'h200, acc: 12'h300, seq: 1'b1, halt: 1'b0, target: 12'h000};
        vecs[3] = '{sel: PC_SEL_BRANCH, branch: 12'h000, acc: 12'hABC, seq: 1'b0, halt: 1'b0, target: 12'h000};
        vecs[4] = '{sel: PC_SEL_HALT,   branch: 12'h040, acc: 12'h999, seq: 1'b0, halt: 1'b1, target: 12'h040};
        vecs[5] = '{sel: PC_SEL_ACC,    branch: 12'h111, acc: 12'h0A5, seq: 1'b0, halt: 1'b0, target: 12'h0A5};

        reset           = 1'b1;
        redirect_valid  = 1'b0;
        pc_sel          = PC_SEL_SEQ;
        branch_addr     = '0;
        acc_lo          = '0;
        resume          = 1'b0;
        bus.instr_ready = 1'b1;

        // Reset state, then start-up latency and streaming.
        repeat (2) @(negedge clk);
        chk_reset_values("rst");
        reset = 1'b0;
        startup_check("boot");
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk_head("stream", 12'(i));
        end

        // Stall: head must hold, fetch must stop within two words of the head.
        p = 12'h006;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_head("stall_hold", p);
        end
        ahead = last_read - p;
        chk("stall_reads_ahead_le2", 32'(ahead <= 12'd2), 32'd1);
        chk("stall_en_off", 32'(prog_en), 32'd0);
        bus.instr_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk_head("stall_release", 12'(p + 12'(i)));
        end
        cur = 12'(p + 12'd6);

        // Redirect table, applied while streaming (pop and ROM return coincide).
        for (int v = 0; v < 6; v++) begin
            p = cur;
            redirect_valid = 1'b1;
            pc_sel         = vecs[v].sel;
            branch_addr    = vecs[v].branch;
            acc_lo         = vecs[v].acc;
            @(negedge clk);
            redirect_valid = 1'b0;
            pc_sel         = PC_SEL_SEQ;
            if (vecs[v].seq) begin
                chk_head("tbl_seq1", 12'(p + 12'd1));
            end else begin
                chk("tbl_flush_valid", 32'(bus.instr_valid), 32'd0);
                chk("tbl_halted", 32'(halted), 32'(vecs[v].halt));
            end
            @(negedge clk);
            if (vecs[v].seq) begin
                chk_head("tbl_seq2", 12'(p + 12'd2));
            end else begin
                chk("tbl_gap_valid", 32'(bus.instr_valid), 32'd0);
            end
            if (vecs[v].halt) begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk("halt_halted", 32'(halted), 32'd1);
                    chk("halt_valid", 32'(bus.instr_valid), 32'd0);
                    chk("halt_en", 32'(prog_en), 32'd0);
                end
                resume = 1'b1;
                @(negedge clk);
                resume = 1'b0;
                chk("resume_halted", 32'(halted), 32'd0);
                chk("resume_valid0", 32'(bus.instr_valid), 32'd0);
                @(negedge clk);
                chk("resume_valid1", 32'(bus.instr_valid), 32'd0);
                @(negedge clk);
                chk_head("resume_first", vecs[v].target);
                cur = vecs[v].target;
            end else begin
                @(negedge clk);
                if (vecs[v].seq) begin
                    chk_head("tbl_seq3", 12'(p + 12'd3));
                    cur = 12'(p + 12'd3);
                end else begin
                    chk_head("tbl_target", vecs[v].target);
                    cur = vecs[v].target;
                end
            end
            for (int i = 1; i <= 3; i++) begin
                @(negedge clk);
                chk_head("tbl_follow", 12'(cur + 12'(i)));
            end
            cur = 12'(cur + 12'd3);
        end

        // Asynchronous reset with the queue loaded; outputs must clear at once.
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_reset_values("async_rst");
        @(negedge clk);
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        startup_check("reboot");
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk_head("reboot_stream", 12'(i));
        end

        // Randomized phase, entered through a known branch so the model is in sync.
        redirect_valid = 1'b1;
        pc_sel         = PC_SEL_BRANCH;
        branch_addr    = 12'h0F0;
        acc_lo         = 12'h000;
        resume         = 1'b0;
        prev_redir  = 1'b1;
        prev_sel    = PC_SEL_BRANCH;
        prev_branch = 12'h0F0;
        prev_acc    = 12'h000;
        prev_resume = 1'b0;
        prev_valid  = 1'b1;
        prev_ready  = 1'b1;
        m_exp       = 12'h000;
        m_halted    = 1'b0;
        idle        = 0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            jmp = prev_redir && ((prev_sel == PC_SEL_BRANCH) || (prev_sel == PC_SEL_ACC));
            hlt = prev_redir && (prev_sel == PC_SEL_HALT);
            was_halted = m_halted;
            if (jmp) begin
                m_exp = (prev_sel == PC_SEL_ACC) ? prev_acc : prev_branch;
                idle  = 0;
            end else if (hlt) begin
                m_exp = prev_branch;
            end else if (prev_valid && prev_ready) begin
                m_exp = 12'(m_exp + 12'd1);
            end
            if (hlt) begin
                m_halted = 1'b1;
            end else if (was_halted && prev_resume) begin
                m_halted = 1'b0;
                idle     = 0;
            end

            chk("rnd_halted", 32'(halted), 32'(m_halted));
            if (m_halted) begin
                chk("rnd_halt_valid", 32'(bus.instr_valid), 32'd0);
            end else if (bus.instr_valid) begin
                chk_head("rnd_head", m_exp);
                idle = 0;
            end else begin
                idle++;
                chk("rnd_latency", 32'(idle <= 2), 32'd1);
            end

            prev_valid      = bus.instr_valid;
            bus.instr_ready = ($urandom_range(3) != 0);
            redirect_valid  = ($urandom_range(15) == 0);
            pc_sel          = 2'($urandom_range(3));
            branch_addr     = 12'($urandom);
            acc_lo          = 12'($urandom);
            resume          = m_halted ? ($urandom_range(3) == 0) : ($urandom_range(7) == 0);
            prev_ready      = bus.instr_ready;
            prev_redir      = redirect_valid;
            prev_sel        = pc_sel;
            prev_branch     = branch_addr;
            prev_acc        = acc_lo;
            prev_resume     = resume;
        end

        redirect_valid = 1'b0;
        resume         = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch and issue unit that feeds `instructionLUT` its inputs. Each cycle it can:
- generate program-memory addresses;
- capture 16-bit instruction words from a synchronous program ROM (1-cycle read latency);
- buffer them in a 2-entry queue;
- present the head word, pre-split into `OP_dk`/`OP_s` fields, with a valid/ready handshake.

It is the producer side of the decoder interface. It acts on PC-select redirects (same encoding as `pcInMux_ctrl`) from the execute stage.

Parameters:
- PC_W, 12, program counter / ROM address width
- INSTR_W, 16, instruction word width
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- prog_addr  out  PC_W  ROM read address
- prog_en  out  1  ROM read enable; data returns next cycle
- prog_data  in  INSTR_W  ROM read data, valid the cycle after prog_en
- redirect_valid  in  1  pulse: apply pc_sel this cycle
- pc_sel  in  2  00 branch to branch_addr, 01 branch to acc_lo, 10 halt, 11 sequential (no-op)
- branch_addr  in  PC_W  absolute target for pc_sel=00; resume address for pc_sel=10
- acc_lo  in  PC_W  accumulator low bits, target for pc_sel=01
- resume  in  1  leave HALT
- instr_out  out  INSTR_W  head instruction (to instruction input)
- OP_dk  out  8  instr_out[15:8]
- OP_s  out  4  instr_out[15:12]
- instr_pc  out  PC_W  address of head instruction
- instr_valid  out  1  head valid
- instr_ready  in  1  decoder/execute accepts head
- halted  out  1  unit in HALT

Behaviour:
- Reset values:
  - prog_addr=RESET_PC, prog_en=0, instr_valid=0, instr_out=NOP (16'h7F80), instr_pc=0, halted=0.
  - Queue empty, no read in flight, state BOOT.
- States:
  - BOOT → RUN after one cycle.
  - RUN → HALT on redirect_valid with pc_sel=10.
  - HALT → RUN on resume.
- Fetch rule (RUN only): prog_en=1 when (queue_count + inflight) < 2. prog_addr = fetch_pc; fetch_pc increments on every issued read.
- PC wrap: fetch_pc increments mod 2^PC_W (0xFFF → 0x000).
- ROM return: if inflight and not squashed, push {prog_data, issued address} into the queue on the next edge.
- Issue: instr_valid = queue non-empty. instr_out, instr_pc, OP_dk and OP_s come combinationally from the head. Head pops on the edge where instr_valid & instr_ready.
- Queue cannot overflow: the fetch rule guarantees at most 2 entries.
- Redirect (pc_sel 00/01) at edge N:
  - queue cleared, in-flight read squashed (its data dropped);
  - fetch_pc ← target; target read issued in cycle N+1;
  - instr_valid=1 with the target instruction in cycle N+2.
- Redirect takes priority over a simultaneous pop and over a simultaneous ROM return.
- pc_sel=11 with redirect_valid: ignored.
- Halt (pc_sel=10): queue cleared, in-flight read squashed, fetch_pc ← branch_addr, halted=1, prog_en=0, instr_valid=0.
- Resume: resume at edge M → halted=0, fetch from fetch_pc in cycle M+1, first valid in cycle M+2.
- resume while not halted: ignored. Redirect while halted: updates fetch_pc, stays halted.
- Throughput: with instr_ready held 1 and no redirects, one instruction per cycle after the initial 2-cycle latency. Stalling instr_ready holds the head stable (instr_out/instr_pc unchanged).
- Async reset mid-operation: everything returns to reset values immediately. The first valid instruction (RESET_PC) appears 2 cycles after BOOT exits.

Decomposition:
- Shared package dsp_pkg:
  - NOP encoding 16'h7F80;
  - pc_sel constants PC_SEL_BRANCH=2'b00, PC_SEL_ACC=2'b01, PC_SEL_HALT=2'b10, PC_SEL_SEQ=2'b11 (shared with the control LUT);
  - PC_W/INSTR_W defaults;
  - OP_dk/OP_s field slice positions.
- One sub-module, fetch_queue: 2-entry FIFO of {instr, pc} with push, pop, flush, count. FSM and PC logic stay in instr_fetch.

Test Plan:
- Reset release, ROM[n]=16'h1000+n, instr_ready=1 → first instr_valid 2 cycles after BOOT exit with instr_pc=0, instr_out=16'h1000. Then consecutive pcs 1,2,3… one per cycle, OP_dk=8'h10, OP_s=4'h1.
- instr_ready=0 for 5 cycles mid-stream → at most 2 ROM reads beyond the head, prog_en=0 thereafter. Head stable. On release, pcs continue with no gaps or duplicates.
- redirect_valid, pc_sel=00, branch_addr=12'h123, with a pop and a ROM return in the same cycle → queued and in-flight words discarded. Next valid is instr_pc=12'h123 two cycles later.
- pc_sel=01, acc_lo=12'hFFE → pcs FFE, FFF, 000, 001 (wrap verified).
- pc_sel=10, branch_addr=12'h040 → halted=1, instr_valid=0, prog_en=0 for 10 cycles. Then resume → instr_pc=12'h040 valid two cycles later.
- Assert reset while queue full and read in flight → outputs immediately at reset values. Fetch restarts at RESET_PC after release.
